// File: rtl/seg7_pkg.sv
// Shared types and the hex-to-segment table for the 7-segment scan driver.
package seg7_pkg;
   typedef enum logic {DRIVE = 1'b0, BLANK = 1'b1} state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // {g,f,e,d,c,b,a}, active-low, indexed by nibble value
   localparam logic [6:0] SEG_TBL [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   function automatic logic [6:0] hex2seg(input logic [3:0] nib);
      return SEG_TBL[nib];
   endfunction
endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low segment pattern.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);
   assign seg = hex2seg(nib);
endmodule

// File: rtl/seg7_scan.sv
// Multiplexed NDIG-digit common-anode display driver with anti-ghost blank gap
// and per-frame snapshot of the displayed value.
module seg7_scan
   import seg7_pkg::*;
#(
   parameter int NDIG      = 4,
   parameter int BLANK_CYC = 16
) (
   input  logic              CLK_IN,
   input  logic              clr,
   input  logic              tick_clk,
   input  logic [4*NDIG-1:0] value,
   input  logic [NDIG-1:0]   dp,
   input  logic              blank_lz,
   output logic [NDIG-1:0]   AN,
   output logic [6:0]        SEG,
   output logic              DP,
   output logic [2:0]        digit_idx,
   output logic              scan_ovf
);
   localparam int             CW       = $clog2(BLANK_CYC + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(BLANK_CYC - 1);
   localparam logic [2:0]     IDX_LAST = 3'(NDIG - 1);

   state_t              state, state_nxt;
   logic                sync1, sync2, prev, scan_en;
   logic [CW-1:0]       bcnt;
   logic [2:0]          idx, hi;
   logic [4*NDIG-1:0]   val_s;
   logic [NDIG-1:0]     dp_s;
   logic                lz_s, blank_done, lz_hit, dp_bit;
   logic [3:0]          nib;
   logic [6:0]          seg_d;
   logic [NDIG-1:0]     an_d;

   // stage-1 output word and stage-2 (pin) register
   logic [NDIG-1:0]     an1, an1_d;
   logic [6:0]          seg1, seg1_d;
   logic                dp1, dp1_d;
   logic [2:0]          idx1;

   // Flops reset high so a tick_clk already high at release is not an edge
   always_ff @(posedge CLK_IN or posedge clr) begin
      if (clr) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         prev  <= 1'b1;
      end else begin
         sync1 <= tick_clk;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign scan_en    = sync2 & ~prev;
   assign blank_done = (state == BLANK) && (bcnt == CNT_LAST);

   always_ff @(posedge CLK_IN or posedge clr) begin
      if (clr) state <= DRIVE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         DRIVE:   if (scan_en)    state_nxt = BLANK;
         BLANK:   if (blank_done) state_nxt = DRIVE;
         default: state_nxt = DRIVE;
      endcase
   end

   always_ff @(posedge CLK_IN or posedge clr) begin
      if (clr) begin
         bcnt     <= '0;
         idx      <= '0;
         val_s    <= '0;
         dp_s     <= '0;
         lz_s     <= 1'b0;
         scan_ovf <= 1'b0;
      end else begin
         bcnt <= (state == BLANK && !blank_done) ? bcnt + CW'(1) : '0;
         if (state == BLANK && scan_en) scan_ovf <= 1'b1;
         if (blank_done) begin
            if (idx == IDX_LAST) begin
               idx   <= '0;
               val_s <= value;
               dp_s  <= dp;
               lz_s  <= blank_lz;
            end else begin
               idx <= idx + 3'd1;
            end
         end
      end
   end

   // Highest nonzero nibble of the snapshot; 0 when the whole value is 0
   always_comb begin
      hi = '0;
      for (int i = 0; i < NDIG; i++)
         if (val_s[4*i +: 4] != 4'h0) hi = 3'(i);
   end

   always_comb begin
      nib    = '0;
      dp_bit = 1'b0;
      an_d   = '1;
      for (int i = 0; i < NDIG; i++) begin
         if (idx == 3'(i)) begin
            nib     = val_s[4*i +: 4];
            dp_bit  = dp_s[i];
            an_d[i] = 1'b0;
         end
      end
   end

   assign lz_hit = lz_s && (idx > hi);

   seg7_decode u_dec (.nib(nib), .seg(seg_d));

   always_comb begin
      an1_d  = '1;
      seg1_d = SEG_BLANK;
      dp1_d  = 1'b1;
      if (state == DRIVE && !lz_hit) begin
         an1_d  = an_d;
         seg1_d = seg_d;
         dp1_d  = ~dp_bit;
      end
   end

   // Two output stages place the gap at edge k+4 after a tick edge
   always_ff @(posedge CLK_IN or posedge clr) begin
      if (clr) begin
         an1       <= '1;
         seg1      <= SEG_BLANK;
         dp1       <= 1'b1;
         idx1      <= '0;
         AN        <= '1;
         SEG       <= SEG_BLANK;
         DP        <= 1'b1;
         digit_idx <= '0;
      end else begin
         an1       <= an1_d;
         seg1      <= seg1_d;
         dp1       <= dp1_d;
         idx1      <= idx;
         AN        <= an1;
         SEG       <= seg1;
         DP        <= dp1;
         digit_idx <= idx1;
      end
   end
endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan: scan order, gap timing, leading-zero blank,
// frame snapshot, overflow flag and async reset.
module tb_seg7_scan;
   logic        CLK_IN = 1'b0;
   logic        clr = 1'b1;
   logic        tick_clk = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  dp = '0;
   logic        blank_lz = 1'b0;
   logic [3:0]  AN;
   logic [6:0]  SEG;
   logic        DP;
   logic [2:0]  digit_idx;
   logic        scan_ovf;

   int n_tot = 0;
   int n_bad = 0;

   seg7_scan #(.NDIG(4), .BLANK_CYC(16)) dut (
      .CLK_IN(CLK_IN), .clr(clr), .tick_clk(tick_clk), .value(value), .dp(dp),
      .blank_lz(blank_lz), .AN(AN), .SEG(SEG), .DP(DP), .digit_idx(digit_idx),
      .scan_ovf(scan_ovf)
   );

   always #5 CLK_IN = ~CLK_IN;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One scan step: checks the old digit up to edge k+3, the 16-cycle gap,
   // and the new digit from edge k+20.
   task automatic step(input string tag, input logic [3:0] old_an, input logic [3:0] new_an,
                       input logic [6:0] new_seg, input logic new_dp, input logic [2:0] new_idx);
      @(posedge CLK_IN); #1 tick_clk = 1'b1;
      repeat (4) @(posedge CLK_IN);
      @(negedge CLK_IN); chk({tag, ".pre"}, AN, old_an);
      @(posedge CLK_IN); @(negedge CLK_IN);
      chk({tag, ".gap0"}, AN, 4'hF);
      chk({tag, ".gap0seg"}, SEG, 7'h7F);
      repeat (15) @(posedge CLK_IN);
      @(negedge CLK_IN); chk({tag, ".gapN"}, AN, 4'hF);
      @(posedge CLK_IN); @(negedge CLK_IN);
      chk({tag, ".an"}, AN, new_an);
      chk({tag, ".seg"}, SEG, new_seg);
      chk({tag, ".dp"}, DP, new_dp);
      chk({tag, ".idx"}, digit_idx, new_idx);
      tick_clk = 1'b0;
   endtask

   initial begin
      // reset with tick_clk toggling
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK_IN); tick_clk = ~tick_clk;
      end
      chk("rst.an", AN, 4'hF);
      chk("rst.seg", SEG, 7'h7F);
      chk("rst.dp", DP, 1'b1);
      chk("rst.idx", digit_idx, 3'd0);
      chk("rst.ovf", scan_ovf, 1'b0);
      tick_clk = 1'b1;
      @(negedge CLK_IN); clr = 1'b0;
      repeat (5) @(negedge CLK_IN);
      chk("rel.an", AN, 4'b1110);
      chk("rel.seg", SEG, 7'h40);
      chk("rel.idx", digit_idx, 3'd0);
      tick_clk = 1'b0;
      repeat (3) @(negedge CLK_IN);

      // plain scan, first frame still shows the reset snapshot (0)
      value = 16'h12AF;
      step("s1", 4'b1110, 4'b1101, 7'h40, 1'b1, 3'd1);
      step("s2", 4'b1101, 4'b1011, 7'h40, 1'b1, 3'd2);
      step("s3", 4'b1011, 4'b0111, 7'h40, 1'b1, 3'd3);
      step("s4", 4'b0111, 4'b1110, 7'h0E, 1'b1, 3'd0);
      step("s5", 4'b1110, 4'b1101, 7'h08, 1'b1, 3'd1);
      step("s6", 4'b1101, 4'b1011, 7'h24, 1'b1, 3'd2);
      step("s7", 4'b1011, 4'b0111, 7'h79, 1'b1, 3'd3);
      step("s8", 4'b0111, 4'b1110, 7'h0E, 1'b1, 3'd0);

      // leading-zero blanking; new inputs take effect at the next wrap
      value = 16'h0050; blank_lz = 1'b1; dp = 4'b1010;
      step("s9",  4'b1110, 4'b1101, 7'h08, 1'b1, 3'd1);
      step("s10", 4'b1101, 4'b1011, 7'h24, 1'b1, 3'd2);
      step("s11", 4'b1011, 4'b0111, 7'h79, 1'b1, 3'd3);
      step("s12", 4'b0111, 4'b1110, 7'h40, 1'b1, 3'd0);
      step("s13", 4'b1110, 4'b1101, 7'h12, 1'b0, 3'd1);
      step("s14", 4'b1101, 4'b1111, 7'h7F, 1'b1, 3'd2);
      step("s15", 4'b1111, 4'b1111, 7'h7F, 1'b1, 3'd3);
      value = 16'h0000;
      step("s16", 4'b1111, 4'b1110, 7'h40, 1'b1, 3'd0);
      step("s17", 4'b1110, 4'b1111, 7'h7F, 1'b1, 3'd1);
      step("s18", 4'b1111, 4'b1111, 7'h7F, 1'b1, 3'd2);
      step("s19", 4'b1111, 4'b1111, 7'h7F, 1'b1, 3'd3);

      // mid-frame value change
      value = 16'h1111; blank_lz = 1'b0; dp = 4'b0000;
      step("s20", 4'b1111, 4'b1110, 7'h79, 1'b1, 3'd0);
      step("s21", 4'b1110, 4'b1101, 7'h79, 1'b1, 3'd1);
      step("s22", 4'b1101, 4'b1011, 7'h79, 1'b1, 3'd2);
      value = 16'h2222;
      step("s23", 4'b1011, 4'b0111, 7'h79, 1'b1, 3'd3);
      step("s24", 4'b0111, 4'b1110, 7'h24, 1'b1, 3'd0);
      chk("ovf.clean", scan_ovf, 1'b0);

      // ticks every 10 cycles: every other one lands in the gap
      for (int i = 0; i < 10; i++) begin
         @(posedge CLK_IN); #1 tick_clk = 1'b1;
         repeat (5) @(posedge CLK_IN);
         #1 tick_clk = 1'b0;
         repeat (4) @(posedge CLK_IN);
      end
      repeat (30) @(posedge CLK_IN);
      @(negedge CLK_IN);
      chk("fast.ovf", scan_ovf, 1'b1);
      chk("fast.idx", digit_idx, 3'd1);
      chk("fast.an", AN, 4'b1101);
      chk("fast.seg", SEG, 7'h24);
      step("s25", 4'b1101, 4'b1011, 7'h24, 1'b1, 3'd2);
      chk("ovf.sticky", scan_ovf, 1'b1);

      // async clear in the middle of the gap
      @(posedge CLK_IN); #1 tick_clk = 1'b1;
      repeat (9) @(posedge CLK_IN);
      #1 clr = 1'b1;
      #1;
      chk("aclr.an", AN, 4'hF);
      chk("aclr.seg", SEG, 7'h7F);
      chk("aclr.dp", DP, 1'b1);
      chk("aclr.idx", digit_idx, 3'd0);
      chk("aclr.ovf", scan_ovf, 1'b0);
      tick_clk = 1'b0;
      @(negedge CLK_IN); clr = 1'b0;
      repeat (4) @(negedge CLK_IN);
      chk("post.an", AN, 4'b1110);
      chk("post.seg", SEG, 7'h40);
      step("s26", 4'b1110, 4'b1101, 7'h40, 1'b1, 3'd1);
      chk("post.ovf", scan_ovf, 1'b0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule
